// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte-stream requesters,
// with optional per-requester message locking to keep multi-byte messages contiguous.
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 3
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [N_REQ-1:0]     req_valid_i,
   input  logic [8*N_REQ-1:0]   req_data_i,
   input  logic [N_REQ-1:0]     req_last_i,
   output logic [N_REQ-1:0]     req_ready_o,
   output logic                 tx_start_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_done_i,
   output logic [ID_W-1:0]      grant_id_o,
   output logic                 busy_o,
   output logic                 locked_o
);

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              locked_q, locked_d;

   logic              win_vld_s;
   logic [ID_W-1:0]   win_idx_s;
   logic [N_REQ-1:0]  win_oh_s;
   logic [7:0]        win_data_s;
   logic              win_last_s;

   // Winner search: smallest round-robin distance from rr_ptr; only grant_id when locked.
   always_comb begin
      int   dist_v;
      int   best_v;
      logic hit_v;
      win_vld_s  = 1'b0;
      win_idx_s  = '0;
      win_oh_s   = '0;
      win_data_s = 8'h00;
      win_last_s = 1'b0;
      best_v     = N_REQ;
      dist_v     = 0;
      hit_v      = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         dist_v = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q)) : (i + N_REQ - int'(rr_ptr_q));
         hit_v  = req_valid_i[i] && (dist_v < best_v) &&
                  (!locked_q || (ID_W'(i) == grant_id_q));
         win_vld_s  = win_vld_s | hit_v;
         win_idx_s  = hit_v ? ID_W'(i) : win_idx_s;
         win_oh_s   = hit_v ? (N_REQ'(1) << i) : win_oh_s;
         win_data_s = hit_v ? req_data_i[8*i +: 8] : win_data_s;
         win_last_s = hit_v ? req_last_i[i] : win_last_s;
         best_v     = hit_v ? dist_v : best_v;
      end
   end

   // Next-state logic and the Mealy req_ready handshake.
   always_comb begin
      state_d     = state_q;
      tx_start_d  = tx_start_q;
      tx_data_d   = tx_data_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      locked_d    = locked_q;
      req_ready_o = '0;
      case (state_q)
         ST_ARB: begin
            if (reset_n_i && tx_done_i && win_vld_s) begin
               req_ready_o = win_oh_s;
               tx_data_d   = win_data_s;
               tx_start_d  = 1'b1;
               grant_id_d  = win_idx_s;
               locked_d    = ~win_last_s;
               // The pointer advances only when a message completes.
               rr_ptr_d    = !win_last_s ? rr_ptr_q :
                             (win_idx_s == ID_W'(N_REQ-1)) ? '0 : win_idx_s + ID_W'(1);
               state_d     = ST_LAUNCH;
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_LAUNCH: begin
            if (!tx_done_i) begin
               tx_start_d = 1'b0;
               state_d    = ST_WAIT;
            end else begin
               tx_start_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (tx_done_i) begin
               state_d = ST_ARB;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d    = ST_ARB;
            tx_start_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= ST_ARB;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         locked_q   <= locked_d;
      end
   end

   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;
   assign grant_id_o = grant_id_q;
   assign locked_o   = locked_q;
   assign busy_o     = (state_q != ST_ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; uart_tx is replaced by a small behavioural
// model whose tx_done drops when it accepts tx_start and rises after FRAME cycles.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int FRAME = 6;

   logic          clk;
   logic          reset_n;
   logic [N-1:0]  req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  req_last;
   logic [N-1:0]  req_ready;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_done;
   logic [2:0]    grant_id;
   logic          busy;
   logic          locked;

   logic          mdl_done;
   int            mcnt;
   logic          force_busy;

   int total = 0;
   int bad   = 0;

   logic [8:0] q [N][$];
   int         log_id [$];
   logic [7:0] log_dat [$];
   logic       log_lock [$];

   logic [N-1:0] rdy_s;
   logic st_s, busy_s, lock_s, done_s;
   int   hs_id;

   uart_tx_arbiter #(.N_REQ(N), .ID_W(3)) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .tx_start_o  (tx_start),
      .tx_data_o   (tx_data),
      .tx_done_i   (tx_done),
      .grant_id_o  (grant_id),
      .busy_o      (busy),
      .locked_o    (locked)
   );

   always #5 clk = ~clk;

   // Behavioural uart_tx: reset by the shared reset, busy for FRAME+1 cycles per byte.
   always @(posedge clk) begin
      if (!reset_n) begin
         mdl_done <= 1'b1;
         mcnt     <= 0;
      end else if (mdl_done && tx_start) begin
         mdl_done <= 1'b0;
         mcnt     <= FRAME;
      end else if (!mdl_done) begin
         if (mcnt == 0) mdl_done <= 1'b1;
         else           mcnt <= mcnt - 1;
      end
   end

   assign tx_done = mdl_done & ~force_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_last[i]        = q[i][0][8];
            req_data[8*i +: 8] = q[i][0][7:0];
         end else begin
            req_valid[i]       = 1'b0;
            req_last[i]        = 1'b0;
            req_data[8*i +: 8] = 8'h00;
         end
      end
   endtask

   // One clock: snapshot at negedge, log any transfer, then advance sources after the edge.
   task automatic cyc();
      logic [N-1:0] hs;
      @(negedge clk);
      rdy_s  = req_ready;
      st_s   = tx_start;
      busy_s = busy;
      lock_s = locked;
      done_s = tx_done;
      hs     = req_valid & req_ready;
      hs_id  = -1;
      if ($countones(req_ready) > 1) chk("ready_onehot", 32'(req_ready), 32'h0);
      for (int i = 0; i < N; i++) if (hs[i]) hs_id = i;
      if (hs_id >= 0) begin
         log_id.push_back(hs_id);
         log_dat.push_back(req_data[8*hs_id +: 8]);
         log_lock.push_back(lock_s);
      end
      @(posedge clk);
      #1;
      if (hs_id >= 0) void'(q[hs_id].pop_front());
      drive();
   endtask

   task automatic drain(input int budget);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         cyc();
         if (hs_id < 0 && !busy_s && done_s &&
             q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain_done", 32'(ok), 32'h1);
   endtask

   task automatic chk_ent(input string tag, input int n, input int id, input logic [7:0] d);
      chk({tag, "_id"},  (log_id.size()  > n) ? 32'(log_id[n])  : 32'hFFFF_FFFF, 32'(id));
      chk({tag, "_dat"}, (log_dat.size() > n) ? 32'(log_dat[n]) : 32'hFFFF_FFFF, 32'(d));
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
   endtask

   initial begin
      int base, rcnt, scnt;
      logic prev_done, ok;
      logic [N-1:0] rany;
      clk = 1'b0; reset_n = 1'b0; force_busy = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;

      // Reset values
      cyc(); cyc();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_start", 32'(tx_start), 32'h0);
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_grant", 32'(grant_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      reset_n = 1'b1;
      cyc();

      // Single byte from requester 0
      base = log_id.size();
      q[0].push_back({1'b1, 8'hA5}); drive();
      rcnt = 0; scnt = 0; prev_done = 1'b0; ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         cyc();
         if (rdy_s[0]) rcnt++;
         if (st_s) scnt++;
         if (c > 0 && hs_id < 0 && !busy_s) begin ok = 1'b1; break; end
         prev_done = done_s;
      end
      chk("single_done", 32'(ok), 32'h1);
      chk("single_ready_cycles", 32'(rcnt), 32'd1);
      chk("single_start_cycles", 32'(scnt), 32'd2);
      chk("single_busy_after_done", 32'(prev_done), 32'h1);
      chk("single_txdata", 32'(tx_data), 32'hA5);
      chk("single_grant", 32'(grant_id), 32'h0);
      chk_ent("single", base, 0, 8'hA5);

      // rr_ptr now 1: requester 3 beats requester 0
      base = log_id.size();
      q[0].push_back({1'b1, 8'h01}); q[3].push_back({1'b1, 8'h03}); drive();
      drain(200);
      chk_ent("rr_first", base, 3, 8'h03);
      chk_ent("rr_second", base + 1, 0, 8'h01);

      // Fairness from rr_ptr 0
      pulse_reset();
      base = log_id.size();
      q[0].push_back({1'b1, 8'h10}); q[0].push_back({1'b1, 8'h10});
      q[1].push_back({1'b1, 8'h11}); q[2].push_back({1'b1, 8'h12});
      q[3].push_back({1'b1, 8'h13}); drive();
      drain(400);
      chk_ent("fair0", base,     0, 8'h10);
      chk_ent("fair1", base + 1, 1, 8'h11);
      chk_ent("fair2", base + 2, 2, 8'h12);
      chk_ent("fair3", base + 3, 3, 8'h13);
      chk_ent("fair4", base + 4, 0, 8'h10);

      // Lock: requester 2 message 21,22,23 while 0 and 3 wait (rr_ptr 1)
      base = log_id.size();
      q[2].push_back({1'b0, 8'h21}); q[2].push_back({1'b0, 8'h22}); q[2].push_back({1'b1, 8'h23});
      q[0].push_back({1'b1, 8'h40}); q[3].push_back({1'b1, 8'h43}); drive();
      drain(400);
      chk_ent("lock0", base,     2, 8'h21);
      chk_ent("lock1", base + 1, 2, 8'h22);
      chk_ent("lock2", base + 2, 2, 8'h23);
      chk_ent("lock3", base + 3, 3, 8'h43);
      chk_ent("lock4", base + 4, 0, 8'h40);
      chk("lock_flag0", (log_lock.size() > base + 4) ?
          32'({log_lock[base], log_lock[base+1], log_lock[base+2], log_lock[base+3], log_lock[base+4]}) :
          32'hFFFF_FFFF, 32'b01100);
      chk("lock_end", 32'(locked), 32'h0);

      // Locked stall: requester 1 holds the lock with valid low
      q[1].push_back({1'b0, 8'h31}); drive();
      drain(200);
      chk("stall_locked", 32'(locked), 32'h1);
      base = log_id.size();
      q[0].push_back({1'b1, 8'h50}); drive();
      rany = '0;
      repeat (30) begin cyc(); rany = rany | rdy_s; end
      chk("stall_no_ready", 32'(rany), 32'h0);
      chk("stall_no_grant", 32'(log_id.size()), 32'(base));
      q[1].push_back({1'b1, 8'h32}); drive();
      drain(200);
      chk_ent("stall_ret", base,     1, 8'h32);
      chk_ent("stall_next", base + 1, 0, 8'h50);

      // Busy transmitter held off in ARB (rr_ptr 1)
      base = log_id.size();
      force_busy = 1'b1;
      q[1].push_back({1'b1, 8'h61}); q[2].push_back({1'b1, 8'h62}); drive();
      rany = '0;
      repeat (5) begin cyc(); rany = rany | rdy_s; end
      chk("busytx_no_ready", 32'(rany), 32'h0);
      chk("busytx_idle", 32'(busy_s), 32'h0);
      force_busy = 1'b0;
      cyc();
      chk("busytx_grant_now", 32'(rdy_s), 32'b0010);
      drain(200);
      chk_ent("busytx0", base,     1, 8'h61);
      chk_ent("busytx1", base + 1, 2, 8'h62);

      // Reset in WAIT while locked (rr_ptr 3)
      q[3].push_back({1'b0, 8'h71}); q[3].push_back({1'b1, 8'h72});
      q[0].push_back({1'b1, 8'h80}); drive();
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         cyc();
         if (busy_s && !st_s) begin ok = 1'b1; break; end
      end
      chk("mid_wait_found", 32'(ok), 32'h1);
      chk("mid_wait_locked", 32'(lock_s), 32'h1);
      chk("mid_wait_data", 32'(tx_data), 32'h71);
      reset_n = 1'b0;
      cyc();
      chk("rst2_ready", 32'(req_ready), 32'h0);
      chk("rst2_start", 32'(tx_start), 32'h0);
      chk("rst2_data", 32'(tx_data), 32'h00);
      chk("rst2_grant", 32'(grant_id), 32'h0);
      chk("rst2_busy", 32'(busy), 32'h0);
      chk("rst2_locked", 32'(locked), 32'h0);
      reset_n = 1'b1;
      base = log_id.size();
      drain(200);
      chk_ent("rst2_first", base,     0, 8'h80);
      chk_ent("rst2_second", base + 1, 3, 8'h72);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
